vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Sequences the VGA raster from the 50 MHz board clock: divides `clk_in` into a pixel-rate enable, runs the horizontal and vertical counters, and drives hsync, vsync, blanking and pixel coordinates for the pixel-generation logic downstream. It replaces ad-hoc use of the divided clock output with a single-clock, enable-based scheduler. All logic runs in the `clk_in` domain.

## Interface
- `CLK_DIV`, 2: `clk_in` cycles per pixel (≥1). 50 MHz / 2 = 25 MHz pixel rate.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BACK`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BACK`, 33: vertical back porch.
- `SYNC_POL`, 0: asserted sync level; 0 = active-low.
- `COUNT_W`, 10: counter width; H_TOTAL−1 and V_TOTAL−1 must fit.
- `clk_in`  input  1  system clock, 50 MHz.
- `reset`  input  1  synchronous, active-high; priority over everything.
- `enable`  input  1  1 = run raster; 0 = return to IDLE.
- `hsync`  output  1  horizontal sync.
- `vsync`  output  1  vertical sync.
- `video_on`  output  1  high while (x, y) is inside the active area.
- `pixel_x`  output  COUNT_W  current horizontal count, 0..H_TOTAL−1.
- `pixel_y`  output  COUNT_W  current vertical count, 0..V_TOTAL−1.
- `pix_tick`  output  1  high in the last `clk_in` cycle of each pixel period.
- `line_start`  output  1  high in the first cycle of pixel (0, y).
- `frame_start`  output  1  high in the first cycle of pixel (0, 0).

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is the vertical equivalent (default 525).
- States: IDLE and RUN.
  - IDLE → RUN when `enable`=1.
  - RUN → IDLE when `enable`=0.
  - `reset` forces IDLE.
- IDLE outputs and reset values:
  - Divider, h and v counts = 0.
  - `hsync` and `vsync` = ~SYNC_POL (deasserted).
  - `video_on`, `pix_tick`, `line_start`, `frame_start` = 0.
  - `pixel_x` and `pixel_y` = 0.
- Divider in RUN:
  - Counts 0..CLK_DIV−1 and wraps.
  - `pix_tick` = 1 when the divider is at CLK_DIV−1.
  - With CLK_DIV=1, `pix_tick` is constantly 1 in RUN.
- Counter advance: at the edge ending a `pix_tick` cycle, h increments.
  - h wraps from H_TOTAL−1 to 0, and v then increments.
  - v wraps from V_TOTAL−1 to 0.
- All outputs are registered and decoded from the next-state counts, so outputs always match `pixel_x`/`pixel_y` in the same cycle.
- `video_on` = (h < H_ACTIVE) and (v < V_ACTIVE).
- `hsync` = SYNC_POL when H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC; otherwise ~SYNC_POL.
- `vsync` = SYNC_POL when V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC; otherwise ~SYNC_POL. vsync is not qualified by h.
- `pixel_x`/`pixel_y` report raw counts, including during blanking.
- `line_start`/`frame_start` are single-cycle pulses, independent of `pix_tick` when CLK_DIV>1.

## Timing
- IDLE → RUN: in the first RUN cycle the counts are (0,0) and `frame_start`, `line_start`, `video_on` are all 1. Latency from `enable` to this cycle is 1 clock.
- Each pixel is held for exactly CLK_DIV cycles.
- Line = H_TOTAL×CLK_DIV cycles (1600 by default). Frame = V_TOTAL×H_TOTAL×CLK_DIV cycles (840000 = 16.8 ms by default).
- `enable` dropping mid-frame: the next edge enters IDLE with the reset values; no partial line is completed.
- Re-enable always restarts at (0,0) with a `frame_start` pulse.
- `reset` mid-frame: same as the `enable` drop, but it overrides `enable`=1. After reset releases with `enable` high, RUN starts 1 cycle later.
- Wrap at (H_TOTAL−1, V_TOTAL−1): the next pixel is (0,0), with `frame_start` and `line_start` high in its first cycle. There is no gap cycle.

## Test plan
- Reset, then hold `enable`=0 for 10 cycles → outputs at reset values (`hsync`=`vsync`=1, others 0). Raise `enable` → next cycle shows (0,0) with `frame_start`=`line_start`=`video_on`=1, and `pix_tick` on alternate cycles.
- Run one line → `hsync` low for exactly 192 clocks, from x=656 through x=751. `video_on` falls at x=640. `line_start` pulses every 1600 clocks.
- Run a full frame → `vsync` low for lines 490–491 (3200 clocks). `frame_start` recurs after exactly 840000 clocks. `video_on` stays 0 for lines 480–524.
- Drop `enable` at x=300, y=200 → IDLE values on the next cycle. Re-enable → restart at (0,0) with `frame_start`.
- Assert `reset` for 1 cycle with `enable`=1 mid-frame → IDLE for that cycle, then (0,0) on the following cycle.
- With CLK_DIV=1, SYNC_POL=1 → `pix_tick` constantly 1, line = 800 clocks, `hsync` high for x=656..751.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-rate enable divider plus horizontal/vertical counters,
// with sync, blanking and coordinate outputs registered from the next-state counts.
module vga_timing_ctrl #(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   COUNT_W  = 10
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COUNT_W-1:0] pixel_x,
    output logic [COUNT_W-1:0] pixel_y,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);

    // Decode bounds carry one extra bit so a sync end equal to the total still fits.
    localparam logic [COUNT_W:0] H_ACT  = (COUNT_W+1)'(H_ACTIVE);
    localparam logic [COUNT_W:0] HS_BEG = (COUNT_W+1)'(H_ACTIVE + H_FRONT);
    localparam logic [COUNT_W:0] HS_END = (COUNT_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COUNT_W:0] V_ACT  = (COUNT_W+1)'(V_ACTIVE);
    localparam logic [COUNT_W:0] VS_BEG = (COUNT_W+1)'(V_ACTIVE + V_FRONT);
    localparam logic [COUNT_W:0] VS_END = (COUNT_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [COUNT_W-1:0] h_cnt, h_nxt;
    logic [COUNT_W-1:0] v_cnt, v_nxt;
    logic [COUNT_W:0]   h_ext, v_ext;

    // From IDLE the next counts are all zero, so the first RUN cycle is pixel (0,0).
    always_comb begin
        div_nxt = '0;
        h_nxt   = '0;
        v_nxt   = '0;
        if (state == RUN) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            h_nxt   = h_cnt;
            v_nxt   = v_cnt;
            if (div_cnt == DIV_LAST) begin
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + COUNT_W'(1);
                end else begin
                    h_nxt = h_cnt + COUNT_W'(1);
                end
            end
        end
    end

    assign h_ext = {1'b0, h_nxt};
    assign v_ext = {1'b0, v_nxt};

    always_ff @(posedge clk_in) begin
        if (reset || !enable) begin
            state       <= IDLE;
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= RUN;
            div_cnt     <= div_nxt;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= (h_ext >= HS_BEG && h_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_ext >= VS_BEG && v_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
            video_on    <= (h_ext < H_ACT) && (v_ext < V_ACT);
            pix_tick    <= (div_nxt == DIV_LAST);
            line_start  <= (div_nxt == '0) && (h_nxt == '0);
            frame_start <= (div_nxt == '0) && (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two small raster geometries checked every cycle against
// an elapsed-time model, plus literal checks of pulse spacing and sync widths.
module tb_vga_timing_ctrl;

    // Geometry A: divided pixel clock, active-low syncs.
    localparam int A_DIV = 2, A_HA = 16, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 8, A_VF = 2, A_VS = 2, A_VB = 3, A_W = 6;
    localparam logic A_POL = 1'b0;
    // Geometry B: undivided pixel clock, active-high syncs.
    localparam int B_DIV = 1, B_HA = 10, B_HF = 2, B_HS = 3, B_HB = 1;
    localparam int B_VA = 6, B_VF = 1, B_VS = 2, B_VB = 1, B_W = 5;
    localparam logic B_POL = 1'b1;

    typedef struct packed {
        logic hs, vs, vid, tick, ls, fs;
        int   x, y;
    } obs_t;

    logic clk = 1'b0;
    logic reset, enable;
    logic a_hs, a_vs, a_vid, a_tick, a_ls, a_fs;
    logic [A_W-1:0] a_x, a_y;
    logic b_hs, b_vs, b_vid, b_tick, b_ls, b_fs;
    logic [B_W-1:0] b_x, b_y;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;
    bit run = 1'b0;
    int t = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_ACTIVE(A_VA), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .SYNC_POL(A_POL), .COUNT_W(A_W)
    ) u_a (
        .clk_in(clk), .reset(reset), .enable(enable),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vid),
        .pixel_x(a_x), .pixel_y(a_y),
        .pix_tick(a_tick), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_ctrl #(
        .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .SYNC_POL(B_POL), .COUNT_W(B_W)
    ) u_b (
        .clk_in(clk), .reset(reset), .enable(enable),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
        .pixel_x(b_x), .pixel_y(b_y),
        .pix_tick(b_tick), .line_start(b_ls), .frame_start(b_fs)
    );

    // Expected outputs from the number of cycles spent in RUN, using plain arithmetic.
    function automatic obs_t model(input bit running, input int tt, input int dv,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb,
                                   input logic pol);
        obs_t o;
        int ht, vt, p, ph;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        o = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        if (running) begin
            p     = tt / dv;
            ph    = tt % dv;
            o.x   = p % ht;
            o.y   = (p / ht) % vt;
            o.tick = (ph == dv - 1);
            o.ls  = (ph == 0) && (o.x == 0);
            o.fs  = o.ls && (o.y == 0);
            o.vid = (o.x < ha) && (o.y < va);
            o.hs  = (o.x >= ha + hf && o.x < ha + hf + hs) ? pol : ~pol;
            o.vs  = (o.y >= va + vf && o.y < va + vf + vs) ? pol : ~pol;
        end
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got hs=%b vs=%b vid=%b tick=%b ls=%b fs=%b x=%0d y=%0d, want hs=%b vs=%b vid=%b tick=%b ls=%b fs=%b x=%0d y=%0d",
                     name, t, act.hs, act.vs, act.vid, act.tick, act.ls, act.fs, act.x, act.y,
                     exp.hs, exp.vs, exp.vid, exp.tick, exp.ls, exp.fs, exp.x, exp.y);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset || !enable) begin
            run = 1'b0;
            t   = 0;
        end else if (!run) begin
            run = 1'b1;
            t   = 0;
        end else begin
            t++;
        end
    end

    always @(negedge clk) begin
        obs_t act;
        if (checking) begin
            act = '{hs: a_hs, vs: a_vs, vid: a_vid, tick: a_tick, ls: a_ls, fs: a_fs,
                    x: int'(a_x), y: int'(a_y)};
            compare("raster_a", act, model(run, t, A_DIV, A_HA, A_HF, A_HS, A_HB,
                                           A_VA, A_VF, A_VS, A_VB, A_POL));
            act = '{hs: b_hs, vs: b_vs, vid: b_vid, tick: b_tick, ls: b_ls, fs: b_fs,
                    x: int'(b_x), y: int'(b_y)};
            compare("raster_b", act, model(run, t, B_DIV, B_HA, B_HF, B_HS, B_HB,
                                           B_VA, B_VF, B_VS, B_VB, B_POL));
        end
    end

    initial begin
        int a_hs_low, a_vs_low, b_ticks, b_hs_high, b_lines, a_fs_second;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        checking = 1'b1;
        #2 reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_hsync_a", int'(a_hs), 1);
        check("idle_vsync_a", int'(a_vs), 1);
        check("idle_hsync_b", int'(b_hs), 0);
        check("idle_x_a", int'(a_x), 0);

        @(posedge clk);
        #2 enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_x_a", int'(a_x), 0);
        check("first_y_a", int'(a_y), 0);
        check("first_fs_a", int'(a_fs), 1);
        check("first_ls_a", int'(a_ls), 1);
        check("first_vid_a", int'(a_vid), 1);
        check("first_tick_a", int'(a_tick), 0);
        check("first_tick_b", int'(b_tick), 1);

        a_hs_low = 0; a_vs_low = 0; b_ticks = 0; b_hs_high = 0; b_lines = 0;
        a_fs_second = -1;
        for (int c = 0; c < 700; c++) begin
            if (c < 46 && !a_hs) a_hs_low++;
            if (c < 690 && !a_vs) a_vs_low++;
            if (c < 16 && b_tick) b_ticks++;
            if (c < 16 && b_hs) b_hs_high++;
            if (c < 160 && b_ls) b_lines++;
            if (c > 0 && a_fs && a_fs_second < 0) a_fs_second = c;
            @(negedge clk);
        end
        check("hsync_low_clocks_a", a_hs_low, 6);
        check("vsync_low_clocks_a", a_vs_low, 92);
        check("frame_period_a", a_fs_second, 690);
        check("tick_per_line_b", b_ticks, 16);
        check("hsync_high_clocks_b", b_hs_high, 3);
        check("lines_per_frame_b", b_lines, 10);

        // Random run lengths, terminated by either an enable drop or a one-cycle reset.
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2 enable = 1'b1;
            repeat ($urandom_range(1, 900)) @(posedge clk);
            if ($urandom_range(0, 1) == 0) begin
                #2 enable = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
            end else begin
                #2 reset = 1'b1;
                @(posedge clk);
                #2 reset = 1'b0;
            end
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
